// File: rtl/mult_stim_gen_if.sv
// Operand stream between the stimulus source and the multiplier characterisation path.
// Carries the (A, B) pair, the exact product and the sample index on a valid/ready handshake.
interface mult_stim_gen_if #(
  parameter int IN_W = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [IN_W-1:0]     A;
  logic [IN_W-1:0]     B;
  logic [2*IN_W-1:0]   exact;
  logic [31:0]         sample_idx;

  modport master (
    output out_valid, A, B, exact, sample_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, A, B, exact, sample_idx,
    output out_ready
  );
endinterface

// File: rtl/mult_stim_gen.sv
// Operand source for approximate-multiplier characterisation: LFSR or exhaustive pairs plus exact product.
// Define STIM_CORNER_EN to prefix each random run with the four corner pairs (0,0),(max,max),(max,0),(0,max).
module mult_stim_gen #(
  parameter int          IN_W        = 8,
  parameter int unsigned NUM_SAMPLES = 1000000,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0000 | 32'h0000_ACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  mult_stim_gen_if.master stream,
  output logic            busy,
  output logic            done
);

  localparam int          PW       = 2 * IN_W;
  localparam logic [31:0] SEED     = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] LAST_IDX = 32'(NUM_SAMPLES - 32'd1);
  localparam logic [31:0] IDX_MAX  = 32'hFFFF_FFFF;
  localparam logic [PW-1:0]   K_LAST  = {PW{1'b1}};
  localparam logic [PW-1:0]   K_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]   K_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [IN_W-1:0] OP_MAX  = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] OP_ZERO = {IN_W{1'b0}};

`ifdef STIM_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic is_corner(input logic m, input logic [31:0] idx);
    return CORNER_EN && !m && (idx < 32'd4);
  endfunction

  function automatic logic [PW-1:0] mul_full(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    return {{IN_W{1'b0}}, a} * {{IN_W{1'b0}}, b};
  endfunction

  state_t            state_r;
  logic              mode_r;
  logic [31:0]       lfsr_r;
  logic [PW-1:0]     k_r;
  logic [31:0]       idx_r;
  logic              valid_r;
  logic [IN_W-1:0]   a_r;
  logic [IN_W-1:0]   b_r;
  logic [PW-1:0]     exact_r;

  logic              accept_s;
  logic              last_s;
  logic [31:0]       lfsr_adv_s;
  logic              src_mode_s;
  logic [31:0]       src_idx_s;
  logic [PW-1:0]     src_k_s;
  logic [PW-1:0]     src_lfsr_s;
  logic [IN_W-1:0]   nxt_a_s;
  logic [IN_W-1:0]   nxt_b_s;
  logic [PW-1:0]     nxt_exact_s;

  assign stream.out_valid  = valid_r;
  assign stream.A          = a_r;
  assign stream.B          = b_r;
  assign stream.exact      = exact_r;
  assign stream.sample_idx = idx_r;

  // Next-sample selection: sample 0 on start, otherwise the successor of the sample being accepted.
  always_comb begin
    accept_s    = (state_r == RUN) && valid_r && stream.out_ready;
    last_s      = mode_r ? (k_r == K_LAST) : (idx_r == LAST_IDX);
    lfsr_adv_s  = (mode_r || is_corner(mode_r, idx_r)) ? lfsr_r : lfsr_step(lfsr_r);
    src_mode_s  = mode;
    src_idx_s   = 32'd0;
    src_k_s     = K_ZERO;
    src_lfsr_s  = lfsr_r[PW-1:0];
    nxt_a_s     = OP_ZERO;
    nxt_b_s     = OP_ZERO;
    if (state_r == RUN) begin
      src_mode_s = mode_r;
      src_idx_s  = (idx_r == IDX_MAX) ? idx_r : (idx_r + 32'd1);
      src_k_s    = k_r + K_ONE;
      src_lfsr_s = lfsr_adv_s[PW-1:0];
    end else begin
      src_mode_s = mode;
    end
    if (src_mode_s) begin
      nxt_a_s = src_k_s[PW-1:IN_W];
      nxt_b_s = src_k_s[IN_W-1:0];
    end else if (is_corner(src_mode_s, src_idx_s)) begin
      case (src_idx_s[1:0])
        2'd0:    begin nxt_a_s = OP_ZERO; nxt_b_s = OP_ZERO; end
        2'd1:    begin nxt_a_s = OP_MAX;  nxt_b_s = OP_MAX;  end
        2'd2:    begin nxt_a_s = OP_MAX;  nxt_b_s = OP_ZERO; end
        2'd3:    begin nxt_a_s = OP_ZERO; nxt_b_s = OP_MAX;  end
        default: begin nxt_a_s = OP_ZERO; nxt_b_s = OP_ZERO; end
      endcase
    end else begin
      nxt_a_s = src_lfsr_s[IN_W-1:0];
      nxt_b_s = src_lfsr_s[PW-1:IN_W];
    end
    nxt_exact_s = mul_full(nxt_a_s, nxt_b_s);
  end

  // Run control, sample registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      mode_r  <= 1'b0;
      lfsr_r  <= SEED;
      k_r     <= K_ZERO;
      idx_r   <= 32'd0;
      valid_r <= 1'b0;
      a_r     <= OP_ZERO;
      b_r     <= OP_ZERO;
      exact_r <= K_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r <= RUN;
            mode_r  <= mode;
            k_r     <= src_k_s;
            idx_r   <= src_idx_s;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            exact_r <= nxt_exact_s;
            valid_r <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (accept_s) begin
            lfsr_r <= lfsr_adv_s;
            if (last_s) begin
              // Outputs keep the last sample; only the handshake and status change.
              state_r <= DONE;
              valid_r <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k_r     <= src_k_s;
              idx_r   <= src_idx_s;
              a_r     <= nxt_a_s;
              b_r     <= nxt_b_s;
              exact_r <= nxt_exact_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_stim_gen.sv
// Directed bench for mult_stim_gen: reset, seed pair, backpressure, sample count, restart, exhaustive sweep.
// Build with STIM_CORNER_EN defined to exercise the corner-pair prefix.
module tb_mult_stim_gen;

`ifdef STIM_CORNER_EN
  localparam bit CORNER = 1'b1;
  localparam int NS     = 6;
`else
  localparam bit CORNER = 1'b0;
  localparam int NS     = 5;
`endif
  localparam logic [31:0] SEED   = 32'hACE1_ACE1;
  localparam logic [7:0]  EXP0_A = CORNER ? 8'h00 : 8'hE1;
  localparam logic [7:0]  EXP0_B = CORNER ? 8'h00 : 8'hAC;
  localparam logic [15:0] EXP0_X = CORNER ? 16'd0 : 16'd38700;
  localparam int          SEED_IDX = CORNER ? 4 : 0;

  logic clk = 1'b0;
  logic rst, start, mode, busy, done;

  mult_stim_gen_if #(.IN_W(8)) bus ();

  mult_stim_gen #(
    .IN_W(8), .NUM_SAMPLES(NS), .LFSR_SEED(32'hACE1_0000 | 32'h0000_ACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .stream(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_lfsr;
  int          m_idx;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Expected {A,B} for a random-mode sample.
  function automatic logic [15:0] exp_ab(input logic [31:0] s, input int idx);
    logic [15:0] r;
    if (CORNER && idx < 4) begin
      case (idx)
        0:       r = 16'h0000;
        1:       r = 16'hFFFF;
        2:       r = 16'hFF00;
        default: r = 16'h00FF;
      endcase
    end else begin
      r = {s[7:0], s[15:8]};
    end
    return r;
  endfunction

  task automatic check_rand_sample(input string tag);
    logic [15:0] ab;
    logic [15:0] ex;
    ab = exp_ab(m_lfsr, m_idx);
    ex = 16'(ab[15:8]) * 16'(ab[7:0]);
    check_val({tag, "_pair"}, {bus.A, bus.B, bus.exact}, {ab, ex});
    check_val({tag, "_idx"}, bus.sample_idx, 32'(m_idx));
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Random run under a 1-0-0-1 ready pattern, with a stray start pulse mid-run.
  task automatic run_random(input string tag, input bit first_run);
    bit          ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          acc = 0;
    bit          held = 1'b0;
    bit          acc_now;
    logic [47:0] prev = 48'd0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (bus.out_valid) begin
        check_rand_sample(tag);
        if (held) check_val({tag, "_hold"}, {bus.A, bus.B, bus.sample_idx}, prev);
        if (first_run && m_idx == SEED_IDX + 1)
          check_val({tag, "_lfsr2"}, {bus.A, bus.B, bus.exact}, {8'h73, 8'hD6, 16'd24610});
        prev = {bus.A, bus.B, bus.sample_idx};
      end
      bus.out_ready = ready_pat[cyc % 4];
      start = (cyc == 2);
      mode  = (cyc == 2);
      acc_now = bus.out_valid && bus.out_ready;
      held    = bus.out_valid && !bus.out_ready;
      @(posedge clk);
      if (acc_now) begin
        acc++;
        if (!(CORNER && m_idx < 4)) m_lfsr = lfsr_step(m_lfsr);
        m_idx++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mode  = 1'b0;
    check_val({tag, "_accepts"}, 64'(acc), 64'(NS));
    check_val({tag, "_status"}, {done, busy, bus.out_valid}, {1'b1, 1'b0, 1'b0});
    check_val({tag, "_held_last"}, {bus.A, bus.B, bus.sample_idx}, prev);
  endtask

  initial begin
    int acc;
    int cycles;
    int ea;
    int eb;
    rst = 1'b1; start = 1'b0; mode = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_out", {bus.out_valid, busy, done, bus.A, bus.B, bus.exact, bus.sample_idx}, 64'd0);
    rst = 1'b0;
    m_lfsr = SEED;
    m_idx  = 0;

    // First sample one cycle after start, then asynchronous reset mid-run.
    pulse_start(1'b0);
    check_val("first_status", {bus.out_valid, busy, done}, {1'b1, 1'b1, 1'b0});
    check_val("first_pair", {bus.A, bus.B, bus.exact, bus.sample_idx}, {EXP0_A, EXP0_B, EXP0_X, 32'd0});
    repeat (2) @(negedge clk);
    check_val("stall_pair", {bus.A, bus.B, bus.exact, bus.sample_idx}, {EXP0_A, EXP0_B, EXP0_X, 32'd0});
    #2 rst = 1'b1;
    #1 check_val("async_reset", {bus.out_valid, busy, done, bus.A, bus.B, bus.exact, bus.sample_idx}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    m_idx  = 0;

    pulse_start(1'b0);
    run_random("rnd", 1'b1);

    // Restart from DONE: LFSR continues, index restarts.
    m_idx = 0;
    pulse_start(1'b0);
    check_val("restart_not_seed", 64'({bus.A, bus.B} == 16'hE1AC), 64'd0);
    check_val("restart_idx", bus.sample_idx, 32'd0);
    run_random("restart", 1'b0);

    // Exhaustive sweep with ready held high.
    bus.out_ready = 1'b1;
    pulse_start(1'b1);
    acc = 0;
    cycles = 0;
    for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
      ea = (acc >> 8) & 255;
      eb = acc & 255;
      check_val("exh_sample", {bus.out_valid, bus.A, bus.B, bus.exact, bus.sample_idx},
                {1'b1, 8'(ea), 8'(eb), 16'(ea * eb), 32'(acc)});
      if (bus.sample_idx == 32'd257)
        check_val("exh_257", {bus.A, bus.B, bus.exact}, {8'd1, 8'd1, 16'd1});
      if (bus.sample_idx == 32'd65535)
        check_val("exh_last", {bus.A, bus.B, bus.exact}, {8'd255, 8'd255, 16'd65025});
      if (bus.out_valid) acc++;
      cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("exh_accepts", 64'(acc), 64'd65536);
    check_val("exh_done_cycle", 64'(cycles), 64'd65536);
    check_val("exh_status", {done, busy, bus.out_valid}, {1'b1, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_stim_gen.md
Name: mult_stim_gen

Overview:
Synthesizable operand source that drives the approximate multipliers under characterisation. Produces (A, B) operand pairs plus the registered exact product on a valid/ready stream. Supports a pseudo-random mode (LFSR) and an exhaustive mode (all pairs).
Downstream, an error accumulator compares the exact product against the DUT product to compute ER/MED/MRED/max. This block is the source end of that comparison stream.

Parameters:
IN_W, 8, operand width in bits; product width is 2*IN_W.
NUM_SAMPLES, 1000000, number of pairs emitted in random mode; must be at least 1.
LFSR_SEED, 32'hACE1_0000 | 32'h0000ACE1, initial LFSR state; a value of 0 is replaced by 1.

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin a run; sampled only in IDLE or DONE
mode  in  1  0 = random, 1 = exhaustive; latched on accepted start
out_ready  in  1  downstream ready
out_valid  out  1  A/B/exact/sample_idx valid
A  out  IN_W  operand A
B  out  IN_W  operand B
exact  out  2*IN_W  A*B, unsigned, full width
sample_idx  out  32  index of the current sample, from 0
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset: one clock; asynchronous, active-high reset.
  - All outputs go to 0.
  - State goes to IDLE.
  - LFSR is loaded with the seed (or 1 if the seed is 0).
  - The mode register is cleared.
- Reset mid-run aborts the run immediately. No partial state survives.
- States:
  - IDLE: on start go to RUN, latch mode, load sample 0 into the output registers, and set out_valid=1 on the next edge. Latency from start to first valid is 1 cycle.
  - RUN: on out_valid && out_ready (accept), the next sample is loaded in the same edge, giving back-to-back throughput of 1 per cycle. When the last sample is accepted, go to DONE and clear out_valid.
  - DONE: done=1, out_valid=0, outputs hold their last values. On start, re-run from IDLE semantics.
    - The LFSR is NOT reseeded on restart; it continues from its current state.
    - Exhaustive counters restart at 0.
- start is ignored while in RUN.
- Handshake rules:
  - While out_valid && !out_ready, A, B, exact and sample_idx are held stable.
  - out_valid never drops without an accept.
- Random mode:
  - 32-bit Galois LFSR, taps 32'h80200003 (x^32+x^22+x^2+x+1); shift right, XOR taps when bit 0 is 1.
  - A = lfsr[IN_W-1:0], B = lfsr[2*IN_W-1:IN_W] of the current state.
  - The LFSR advances exactly once per accept.
  - Total samples = NUM_SAMPLES.
- Exhaustive mode:
  - 2*IN_W-bit counter k; A = k[2*IN_W-1:IN_W], B = k[IN_W-1:0]; B is the inner loop.
  - Total samples = 2^(2*IN_W), ignoring NUM_SAMPLES.
  - The last sample is A = B = all-ones.
  - Counter wrap-around is never reached, because DONE is entered on the last accept.
- Exact product is computed combinationally from the next operands and registered together with them, so it is always aligned with A/B.
- sample_idx increments by 1 per accept; it is 32 bits and saturates at 2^32-1 (unreachable with the defaults).
- NUM_SAMPLES = 1: a single sample is emitted, then DONE.

Optional Feature:
Macro STIM_CORNER_EN.
- Defined: in random mode only, the first four samples are fixed corner pairs, in this order: (0,0), (max,max), (max,0), (0,max), where max = 2^IN_W-1.
  - These count toward NUM_SAMPLES.
  - The LFSR does not advance during them.
  - The fifth sample is the seed-derived pair.
  - If NUM_SAMPLES < 4, only the first NUM_SAMPLES corners are emitted.
- Not defined: random mode starts directly from the seed-derived pair. Exhaustive mode is unaffected in both cases.

Test Plan:
- Reset value and seed: assert rst mid-RUN -> out_valid=0, busy=0, done=0, A=B=exact=0 asynchronously; then start with mode=0 and default seed -> next cycle out_valid=1, A=8'hE1, B=8'hAC, exact=38700, sample_idx=0.
- Exhaustive sweep: mode=1, out_ready held 1 -> sample_idx=257 gives A=1, B=1, exact=1; sample_idx=65535 gives A=255, B=255, exact=65025; done=1 on the following cycle; exactly 65536 accepts.
- Backpressure: random mode, out_ready toggling 1-0-0-1 -> outputs stable during ready=0; no sample skipped or duplicated (LFSR sequence matches the reference model).
- Sample count: NUM_SAMPLES=5 -> exactly 5 accepts, then done=1 and busy=0; start pulsed during RUN has no effect on the count.
- Restart: start in DONE in random mode -> first new pair equals the LFSR continuation (not the seed pair); sample_idx restarts at 0.
- STIM_CORNER_EN defined, NUM_SAMPLES=6 -> pairs (0,0), (255,255) with exact=65025, (255,0), (0,255), then (E1,AC), then the next LFSR pair; done after 6 accepts.
